// File: rtl/fft_input_reorder.sv
// Ping-pong frame buffer feeding the FFT core: natural-order samples in,
// bit-reversed frames out as N back-to-back words framed by start_o.
module fft_input_reorder #(
   parameter int N     = 1024,
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               flush_i,
   input  logic               s_valid_i,
   output logic               s_ready_o,
   input  logic [IN_W-1:0]    s_data_i,
   input  logic               fft_idle_i,
   output logic               start_o,
   output logic [OUT_W-1:0]   x0_re_o,
   output logic [OUT_W-1:0]   x0_im_o,
   output logic [15:0]        frame_cnt_o
);
   localparam int AW = $clog2(N);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

   function automatic logic [AW-1:0] rev(input logic [AW-1:0] k);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
      return r;
   endfunction

   logic [OUT_W-1:0] mem [0:2*N-1];
   logic [OUT_W-1:0] ram_rd_q;
   logic [AW:0]      raddr;
   logic             rd_en;
   logic             accept;
   logic [OUT_W-1:0] sext;

   state_t           state_q, state_d;
   logic [1:0]       bank_full_q, bank_full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
   logic             start_q, start_d;
   logic [OUT_W-1:0] x0_re_q, x0_re_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;

   assign s_ready_o   = ~bank_full_q[wr_bank_q];
   assign accept      = s_valid_i & s_ready_o & ~flush_i;
   assign sext        = OUT_W'($signed(s_data_i));
   assign start_o     = start_q;
   assign x0_re_o     = x0_re_q;
   assign x0_im_o     = '0;
   assign frame_cnt_o = frame_cnt_q;

   always_comb begin
      state_d     = state_q;
      bank_full_d = bank_full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_ptr_d    = wr_ptr_q;
      rd_cnt_d    = rd_cnt_q;
      start_d     = start_q;
      x0_re_d     = x0_re_q;
      frame_cnt_d = frame_cnt_q;
      rd_en       = 1'b0;
      raddr       = {rd_bank_q, rev(rd_cnt_q + AW'(2))};

      if (accept) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (wr_ptr_q == AW'(N-1)) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
         end
      end

      // ram_rd_q always runs one word ahead of x0_re_q while streaming
      case (state_q)
         IDLE: begin
            start_d = 1'b0;
            if (bank_full_q[rd_bank_q] && fft_idle_i) begin
               state_d = PRIME;
               rd_en   = 1'b1;
               raddr   = {rd_bank_q, rev('0)};
            end
         end
         PRIME: begin
            rd_en   = 1'b1;
            raddr   = {rd_bank_q, rev(AW'(1))};
            x0_re_d = ram_rd_q;
            start_d = 1'b1;
            state_d = STREAM;
         end
         STREAM: begin
            rd_cnt_d = rd_cnt_q + AW'(1);
            if (rd_cnt_q == AW'(N-1)) begin
               bank_full_d[rd_bank_q] = 1'b0;
               rd_bank_d              = ~rd_bank_q;
               rd_cnt_d               = '0;
               frame_cnt_d            = frame_cnt_q + 16'd1;
               start_d                = 1'b0;
               state_d                = IDLE;
            end else begin
               rd_en   = 1'b1;
               x0_re_d = ram_rd_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush_i) begin
         state_d     = IDLE;
         bank_full_d = '0;
         wr_bank_d   = 1'b0;
         rd_bank_d   = 1'b0;
         wr_ptr_d    = '0;
         rd_cnt_d    = '0;
         start_d     = 1'b0;
         x0_re_d     = '0;
         frame_cnt_d = frame_cnt_q;
         rd_en       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[{wr_bank_q, wr_ptr_q}] <= sext;
      if (rd_en) ram_rd_q <= mem[raddr];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         bank_full_q <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_cnt_q    <= '0;
         start_q     <= 1'b0;
         x0_re_q     <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         bank_full_q <= bank_full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_cnt_q    <= rd_cnt_d;
         start_q     <= start_d;
         x0_re_q     <= x0_re_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
endmodule

// File: tb/tb_fft_input_reorder.sv
// Directed bench for fft_input_reorder: frames are modelled as accepted, and a
// monitor compares every streamed word against the bit-reversed model frame.
module tb_fft_input_reorder;
   localparam int N     = 1024;
   localparam int AW    = 10;
   localparam int IN_W  = 16;
   localparam int OUT_W = 32;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             flush_i = 1'b0;
   logic             s_valid_i = 1'b0;
   logic             s_ready_o;
   logic [IN_W-1:0]  s_data_i = '0;
   logic             fft_idle_i = 1'b0;
   logic             start_o;
   logic [OUT_W-1:0] x0_re_o;
   logic [OUT_W-1:0] x0_im_o;
   logic [15:0]      frame_cnt_o;

   always #5 clk = ~clk;

   fft_input_reorder #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rstn(rstn), .flush_i(flush_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
      .fft_idle_i(fft_idle_i), .start_o(start_o),
      .x0_re_o(x0_re_o), .x0_im_o(x0_im_o), .frame_cnt_o(frame_cnt_o)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] fb [N];
   int          acc_idx = 0;
   bit          abort_f = 1'b0;
   int          run = 0;
   int          acc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int brev(input int k);
      int r = 0;
      for (int i = 0; i < AW; i++) r = (r << 1) | ((k >> i) & 1);
      return r;
   endfunction

   task automatic push_sample(input logic [15:0] v);
      fb[acc_idx] = {{16{v[15]}}, v};
      acc_idx++;
      if (acc_idx == N) begin
         for (int k = 0; k < N; k++) exp_q.push_back(fb[brev(k)]);
         acc_idx = 0;
      end
   endtask

   // called and returns on a negedge; pat 0 ramp, 1 sign corners, 2 random
   task automatic feed(input int n, input int pat, input int gap_pct, input int budget,
                       output int acc_o);
      int cyc = 0;
      logic [15:0] v;
      acc_o = 0;
      while (acc_o < n && cyc < budget) begin
         case (pat)
            0: v = acc_o[15:0];
            1: v = (acc_o == 0) ? 16'h8000 : (acc_o == 512) ? 16'h7FFF : acc_o[15:0];
            default: v = 16'($urandom);
         endcase
         if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) s_valid_i = 1'b0;
         else begin
            s_valid_i = 1'b1;
            s_data_i  = v;
            if (s_ready_o) begin
               push_sample(v);
               acc_o++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      s_valid_i = 1'b0;
   endtask

   task automatic wait_start(input logic val, input int budget, input string tag);
      int c = 0;
      while (start_o !== val && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      chk(tag, 32'(start_o), 32'(val));
   endtask

   task automatic wait_fcnt(input int v, input int budget, input string tag);
      int c = 0;
      while (frame_cnt_o != 16'(v) && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      chk(tag, 32'(frame_cnt_o), v);
   endtask

   always begin
      @(posedge clk); #1;
      if (start_o) begin
         run++;
         chk("im_zero", x0_im_o, 0);
         chk("exp_avail", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("word", x0_re_o, exp_q.pop_front());
      end else begin
         if (run != 0 && !abort_f) chk("run_len", run, N);
         run = 0;
      end
   end

   initial begin
      // reset
      repeat (3) @(negedge clk);
      chk("rst_start", 32'(start_o), 0);
      chk("rst_x0", x0_re_o, 0);
      chk("rst_im", x0_im_o, 0);
      chk("rst_fcnt", 32'(frame_cnt_o), 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(s_ready_o), 1);

      // ramp frame
      fft_idle_i = 1'b1;
      feed(N, 0, 0, 2*N, acc);
      chk("t2_acc", acc, N);
      wait_start(1'b1, 50, "t2_start");
      chk("t2_w0", x0_re_o, 0);
      @(posedge clk); #1; chk("t2_w1", x0_re_o, 512);
      @(posedge clk); #1; chk("t2_w2", x0_re_o, 256);
      @(posedge clk); #1; chk("t2_w3", x0_re_o, 768);
      wait_start(1'b0, 2*N, "t2_end");
      chk("t2_fcnt", 32'(frame_cnt_o), 1);
      chk("t2_hold", x0_re_o, 1023);

      // sign extension corners
      @(negedge clk);
      feed(N, 1, 0, 2*N, acc);
      chk("t3_acc", acc, N);
      wait_start(1'b1, 50, "t3_start");
      chk("t3_neg", x0_re_o, 32'hFFFF8000);
      @(posedge clk); #1; chk("t3_pos", x0_re_o, 32'h00007FFF);
      wait_start(1'b0, 2*N, "t3_end");
      chk("t3_fcnt", 32'(frame_cnt_o), 2);

      // backpressure: both banks fill, core held off
      @(negedge clk);
      fft_idle_i = 1'b0;
      feed(2100, 0, 0, 2300, acc);
      chk("t4_acc", acc, 2*N);
      chk("t4_ready", 32'(s_ready_o), 0);
      chk("t4_nostart", 32'(start_o), 0);
      fft_idle_i = 1'b1;
      wait_start(1'b1, 20, "t4_f0_start");
      wait_start(1'b0, 2*N, "t4_f0_end");
      chk("t4_ready_after", 32'(s_ready_o), 1);
      chk("t4_fcnt0", 32'(frame_cnt_o), 3);
      wait_start(1'b1, 20, "t4_f1_start");
      wait_start(1'b0, 2*N, "t4_f1_end");
      chk("t4_fcnt1", 32'(frame_cnt_o), 4);

      // overlapped fill and stream with random gaps
      @(negedge clk);
      feed(3*N, 2, 20, 8*N, acc);
      chk("t5_acc", acc, 3*N);
      wait_fcnt(7, 4*N, "t5_fcnt");
      chk("t5_drain", exp_q.size(), 0);

      // flush with a simultaneous valid: partial frame and that sample discarded
      @(negedge clk);
      fft_idle_i = 1'b0;
      feed(100, 2, 0, 200, acc);
      s_valid_i = 1'b1;
      s_data_i  = 16'h1234;
      flush_i   = 1'b1;
      @(negedge clk);
      flush_i   = 1'b0;
      s_valid_i = 1'b0;
      acc_idx   = 0;
      chk("fl_ready", 32'(s_ready_o), 1);
      chk("fl_fcnt", 32'(frame_cnt_o), 7);
      fft_idle_i = 1'b1;
      feed(N, 2, 0, 2*N, acc);
      chk("fl_acc", acc, N);
      wait_fcnt(8, 3*N, "fl_fcnt_after");

      // reset in the middle of a stream
      @(negedge clk);
      feed(N, 2, 0, 2*N, acc);
      wait_start(1'b1, 50, "t6_start");
      repeat (300) @(posedge clk);
      @(negedge clk);
      abort_f = 1'b1;
      rstn    = 1'b0;
      #1;
      chk("t6_start_low", 32'(start_o), 0);
      chk("t6_x0", x0_re_o, 0);
      chk("t6_ready", 32'(s_ready_o), 1);
      chk("t6_fcnt", 32'(frame_cnt_o), 0);
      exp_q.delete();
      acc_idx = 0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      abort_f = 1'b0;
      feed(N, 2, 0, 2*N, acc);
      chk("t6_acc", acc, N);
      wait_fcnt(1, 3*N, "t6_fcnt_after");
      chk("t6_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
